// File: rtl/fifo_alu_sequencer.sv
// Sequencer between an 8-bit FIFO and a 16-bit ALU: pops four bytes, issues one ALU op,
// waits for completion with a timeout and offers the result on a valid/ready port.
module fifo_alu_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_en,
   input  logic [2:0]        cfg_op,
   input  logic              clr_err,
   output logic              fifo_rd_en,
   input  logic [7:0]        fifo_data,
   input  logic              fifo_empty,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_start,
   input  logic [15:0]       alu_result,
   input  logic              alu_done,
   input  logic              alu_ovf,
   output logic [15:0]       res_data,
   output logic              res_ovf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  op_count
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t          state;
   logic [2:0]      rd_cnt;
   logic [2:0]      cap_cnt;
   logic            pend;
   logic [TW-1:0]   tcnt;

   // Pop whenever data is available and fewer than four bytes have been requested
   assign fifo_rd_en = (state == S_FETCH) && !fifo_empty && (rd_cnt < 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rd_cnt      <= '0;
         cap_cnt     <= '0;
         pend        <= 1'b0;
         tcnt        <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         alu_start   <= 1'b0;
         res_data    <= '0;
         res_ovf     <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         op_count    <= '0;
      end else begin
         alu_start <= 1'b0;
         if (clr_err) begin
            err_timeout <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (cfg_en) begin
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  alu_op  <= cfg_op;
                  rd_cnt  <= '0;
                  cap_cnt <= '0;
                  pend    <= 1'b0;
               end
            end
            S_FETCH: begin
               pend <= fifo_rd_en;
               if (fifo_rd_en) begin
                  rd_cnt <= rd_cnt + 3'd1;
               end
               // Byte of the previous cycle's pop lands now, little-endian A then B
               if (pend) begin
                  case (cap_cnt[1:0])
                     2'd0: alu_a[7:0]  <= fifo_data;
                     2'd1: alu_a[15:8] <= fifo_data;
                     2'd2: alu_b[7:0]  <= fifo_data;
                     2'd3: alu_b[15:8] <= fifo_data;
                  endcase
                  cap_cnt <= cap_cnt + 3'd1;
               end
               if (cap_cnt == 3'd4) begin
                  state     <= S_ISSUE;
                  alu_start <= 1'b1;
                  tcnt      <= '0;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
               tcnt  <= '0;
            end
            S_WAIT: begin
               // Completion takes priority over the timeout in the limit cycle
               if (alu_done) begin
                  res_data  <= alu_result;
                  res_ovf   <= alu_ovf;
                  res_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else if (tcnt + TW'(1) == TW'(TIMEOUT_CYC - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
                  busy        <= 1'b0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= S_IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// Scoreboard bench for fifo_alu_sequencer with behavioural FIFO and ALU models.
module tb_fifo_alu_sequencer;

   localparam int unsigned TIMEOUT_CYC = 64;
   localparam int unsigned CNT_W       = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_en = 1'b0;
   logic [2:0]        cfg_op = 3'd0;
   logic              clr_err = 1'b0;
   logic              fifo_rd_en;
   logic [7:0]        fifo_data = 8'h00;
   logic              fifo_empty = 1'b1;
   logic [15:0]       alu_a;
   logic [15:0]       alu_b;
   logic [2:0]        alu_op;
   logic              alu_start;
   logic [15:0]       alu_result = 16'h0000;
   logic              alu_done = 1'b0;
   logic              alu_ovf = 1'b0;
   logic [15:0]       res_data;
   logic              res_ovf;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic              busy;
   logic              err_timeout;
   logic [CNT_W-1:0]  op_count;

   typedef struct packed {
      logic [15:0] data;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  fq[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          got = 0;
   int          alu_lat = 1;
   int          alu_pend = 0;
   logic [7:0]  pop_byte;

   fifo_alu_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_op(cfg_op), .clr_err(clr_err),
      .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_result(alu_result), .alu_done(alu_done), .alu_ovf(alu_ovf),
      .res_data(res_data), .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .err_timeout(err_timeout), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] alu_calc(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {(a < b), a - b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   // FIFO: registered read data and registered empty flag
   always @(posedge clk) begin
      if (fifo_rd_en && fq.size() > 0) begin
         pop_byte = fq.pop_front();
         fifo_data <= pop_byte;
      end
      fifo_empty <= (fq.size() == 0);
   end

   // ALU: done alu_lat cycles after start; alu_lat of 0 never completes
   always @(posedge clk) begin
      alu_done <= 1'b0;
      if (alu_start && alu_lat > 0) alu_pend = alu_lat;
      if (alu_pend > 0) begin
         alu_pend = alu_pend - 1;
         if (alu_pend == 0) begin
            alu_done <= 1'b1;
            {alu_ovf, alu_result} <= alu_calc(alu_op, alu_a, alu_b);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         got = got + 1;
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_result actual=%h/%b required=none", res_data, res_ovf);
         end else begin
            mon_e = sb.pop_front();
            if (res_data !== mon_e.data || res_ovf !== mon_e.ovf) begin
               errors = errors + 1;
               $display("FAIL result_%0d actual=%h/%b required=%h/%b", got, res_data, res_ovf,
                        mon_e.data, mon_e.ovf);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3);
      fq.push_back(b0);
      fq.push_back(b1);
      fq.push_back(b2);
      fq.push_back(b3);
   endtask

   task automatic expect_res(input logic [15:0] d, input logic o);
      sb.push_back({d, o});
   endtask

   task automatic start_op(input logic [2:0] op);
      int n;
      n = 0;
      cfg_op = op;
      cfg_en = 1'b1;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      cfg_en = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n;
      n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (!alu_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(alu_start), 32'd1);
   endtask

   task automatic reset_check(input string pfx);
      check({pfx, "_ab"}, {alu_a, alu_b}, 32'd0);
      check({pfx, "_res"}, 32'({res_data, res_ovf, res_valid}), 32'd0);
      check({pfx, "_ctl"}, 32'({fifo_rd_en, alu_op, alu_start, busy, err_timeout, op_count}), 32'd0);
   endtask

   initial begin
      int lat, starts, bad, t, n, started, got_base;
      logic prev, opchk;
      logic [15:0] cap_a, cap_b, hold_d;

      tick(2);
      reset_check("reset");
      res_ready = 1'b1;
      rst_n = 1'b1;
      tick(2);

      // Basic add with minimum latency
      push4(8'h34, 8'h12, 8'h78, 8'h56);
      expect_res(16'h68AC, 1'b0);
      tick(2);
      start_op(3'd0);
      lat = 0;
      starts = 0;
      cap_a = '0;
      cap_b = '0;
      while (!res_valid && lat < 40) begin
         if (alu_start) begin
            starts++;
            cap_a = alu_a;
            cap_b = alu_b;
         end
         @(negedge clk);
         lat++;
      end
      check("t1_latency", 32'(lat), 32'd8);
      check("t1_start_pulses", 32'(starts), 32'd1);
      check("t1_alu_a", 32'(cap_a), 32'h1234);
      check("t1_alu_b", 32'(cap_b), 32'h5678);
      wait_idle("t1_idle", 20);
      check("t1_count", 32'(op_count), 32'd1);

      // FETCH stall on empty FIFO
      fq.push_back(8'h10);
      fq.push_back(8'h00);
      expect_res(16'h000D, 1'b0);
      tick(2);
      start_op(3'd1);
      tick(6);
      bad = 0;
      repeat (20) begin
         if (fifo_rd_en || !busy || alu_start) bad++;
         @(negedge clk);
      end
      check("t2_stall", 32'(bad), 32'd0);
      fq.push_back(8'h03);
      fq.push_back(8'h00);
      wait_idle("t2_idle", 60);
      check("t2_count", 32'(op_count), 32'd2);

      // Timeout, then the following op proceeds
      push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      push4(8'hFF, 8'h00, 8'h0F, 8'h0F);
      expect_res(16'h0FF0, 1'b0);
      alu_lat = 0;
      tick(2);
      cfg_op = 3'd2;
      cfg_en = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      cfg_op = 3'd4;
      wait_start("t3_start");
      t = 0;
      bad = 0;
      while (!err_timeout && t < 200) begin
         @(negedge clk);
         t++;
         if (res_valid) bad++;
      end
      check("t3_timeout_delay", 32'(t), TIMEOUT_CYC);
      check("t3_no_valid", 32'(bad), 32'd0);
      alu_lat = 1;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      cfg_en = 1'b0;
      check("t3_restart", 32'(busy), 32'd1);
      wait_idle("t3_idle", 60);
      check("t3_count", 32'(op_count), 32'd3);
      check("t3_err_sticky", 32'(err_timeout), 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t3_err_clr", 32'(err_timeout), 32'd0);

      // Backpressure on the result port
      push4(8'hFF, 8'hFF, 8'h01, 8'h00);
      expect_res(16'h0000, 1'b1);
      push4(8'h11, 8'h22, 8'h33, 8'h44);
      res_ready = 1'b0;
      tick(2);
      start_op(3'd0);
      n = 0;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      hold_d = res_data;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!res_valid || res_data !== hold_d || fifo_rd_en || op_count != 8'd3) bad++;
      end
      check("t4_hold", 32'(bad), 32'd0);
      check("t4_data", 32'(res_data), 32'h0000);
      res_ready = 1'b1;
      wait_idle("t4_idle", 20);
      check("t4_count", 32'(op_count), 32'd4);
      check("t4_fifo_left", 32'(fq.size()), 32'd4);

      // Asynchronous reset during WAIT; the late done must be ignored
      alu_lat = 10;
      tick(1);
      start_op(3'd2);
      wait_start("t5_start");
      tick(3);
      check("t5_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_check("t5_rst");
      tick(1);
      rst_n = 1'b1;
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid || busy || alu_start || fifo_rd_en || op_count != 8'd0) bad++;
      end
      check("t5_late_done", 32'(bad), 32'd0);

      // 256 ops wrap the counter; opcode change mid-FETCH does not affect the op
      alu_lat = 1;
      for (int i = 0; i < 256; i++) begin
         push4(8'(i), 8'h00, 8'h00, 8'(i));
         expect_res(16'(i * 257), 1'b0);
      end
      tick(2);
      got_base = got;
      cfg_op = 3'd0;
      cfg_en = 1'b1;
      started = 0;
      prev = busy;
      opchk = 1'b0;
      n = 0;
      while (started < 256 && n < 8000) begin
         @(negedge clk);
         n++;
         if (busy && !prev) begin
            started++;
            if (started == 1) cfg_op = 3'd1;
            if (started == 256) cfg_en = 1'b0;
         end
         if (alu_start && !opchk) begin
            opchk = 1'b1;
            check("t6_latched_op", 32'(alu_op), 32'd0);
            cfg_op = 3'd0;
         end
         prev = busy;
      end
      cfg_en = 1'b0;
      check("t6_started", 32'(started), 32'd256);
      wait_idle("t6_idle", 100);
      check("t6_wrap", 32'(op_count), 32'd0);
      check("t6_results", 32'(got - got_base), 32'd256);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
